ref_row_fetcher: RTL and testbench
==================================

REF_ROW_FETCHER -- requirements
Module: ref_row_fetcher

Interface
REQ-001 Parameter PIXEL_W, default 8, bits per pixel.
REQ-002 Parameter ROW_PIX, default 15, pixels per output row (8+7 filter taps).
REQ-003 Parameter NUM_ROWS, default 15, rows per block.
REQ-004 Parameter ADDR_W, default 16, memory word-address width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a block fetch when idle.
REQ-008 base_addr  in  ADDR_W  word address of the block's top-left pixel, sampled on accepted start.
REQ-009 stride  in  ADDR_W  words per frame line, sampled on accepted start.
REQ-010 frame_rows  in  8  valid frame lines below base_addr, sampled on accepted start; used only with FETCHER_PAD_EN.
REQ-011 mem_rd_en  out  1  memory read strobe.
REQ-012 mem_addr  out  ADDR_W  memory read word address.
REQ-013 mem_rdata  in  8*PIXEL_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 row_out  out  ROW_PIX*PIXEL_W  pixel i at bits [i*PIXEL_W +: PIXEL_W].
REQ-015 row_valid  out  1  row_out holds a valid row.
REQ-016 row_ready  in  1  consumer (interpolator input shift register) accepts row.
REQ-017 busy  out  1  high from accepted start until last row accepted.
REQ-018 done  out  1  one-cycle pulse on acceptance of row NUM_ROWS-1.

Function
REQ-019 FSM states IDLE, RD_LO, RD_HI, CAP, DRAIN; IDLE->RD_LO on start; RD_LO->RD_HI; RD_HI->CAP; CAP->RD_LO if rows remain and FIFO has a free slot, CAP->DRAIN when all rows fetched, else hold CAP; DRAIN->IDLE when FIFO empty.
REQ-020 RD_LO issues mem_rd_en with mem_addr = row address; RD_HI issues row address + 1; mem_rd_en low in all other states.
REQ-021 Row address r = base_addr + r*stride, computed by accumulation, modulo 2^ADDR_W (wrap permitted).
REQ-022 Low word supplies pixels 0..7, high word pixels 8..ROW_PIX-1; unused high-word pixels discarded.
REQ-023 In CAP the assembled row is pushed into a 2-entry FIFO; a read is never issued unless a FIFO slot is guaranteed at CAP.
REQ-024 Row transfers when row_valid && row_ready; row_out/row_valid driven from FIFO head, stable while row_valid && !row_ready.
REQ-025 Rows emitted in order 0..NUM_ROWS-1; exactly NUM_ROWS transfers per start.
REQ-026 start while busy is ignored.
REQ-027 Simultaneous push and pop on a full FIFO is legal and preserves occupancy.
REQ-028 Minimum latency start -> first row_valid = 4 cycles; steady-state throughput 1 row per 3 cycles with row_ready held high.
REQ-029 done and busy-fall occur in the same cycle as the final transfer's following edge.

Reset
REQ-030 rst low forces state IDLE, FIFO empty, row counter 0, and outputs mem_rd_en=0, mem_addr=0, row_out=0, row_valid=0, busy=0, done=0, immediately and regardless of clk.
REQ-031 Reset mid-block abandons the block; the in-flight memory response is ignored; no partial row is emitted after release.

Configuration
REQ-032 With FETCHER_PAD_EN defined, rows r >= frame_rows reuse the address of row frame_rows-1 (bottom-edge replication); frame_rows=0 treated as 1.
REQ-033 Without FETCHER_PAD_EN, frame_rows is ignored and every row uses REQ-021 addressing.

Structure
REQ-034 Shared package ref_fetch_pkg holds the FSM state enum, PIXEL_W/ROW_PIX/NUM_ROWS defaults and the memory word width constant.
REQ-035 The 2-entry FIFO is a separate sub-module row_skid_fifo; address generation and FSM remain in ref_row_fetcher.

Verification
REQ-036 base_addr=0x0100, stride=4, row_ready=1, memory word = address pattern -> 15 rows, row r addresses 0x0100+4r and +1, first row_valid 4 cycles after start, done on 15th transfer.
REQ-037 row_ready low for 10 cycles after first row -> row_out stable, at most 2 rows buffered, mem_rd_en stays low until a slot frees, no row lost or duplicated.
REQ-038 base_addr=0xFFFE, stride=1 -> addresses wrap to 0x0000, 0x0001...; data ordering correct.
REQ-039 FETCHER_PAD_EN, frame_rows=5 -> rows 5..14 equal row 4 and read address of row 4.
REQ-040 rst asserted at row 7 mid-RD_HI -> outputs zero immediately; after release new start yields a clean 15-row block.
REQ-041 start pulsed while busy -> ignored; exactly 15 transfers and one done pulse.

Source files
------------

// File: rtl/ref_fetch_pkg.sv
// ref_fetch_pkg
//   Shared types and defaults for the reference-row fetcher.
//   - default geometry: PIXEL_W, ROW_PIX (8 + 7 filter taps), NUM_ROWS, ADDR_W
//   - WORD_PIX: pixels carried by one memory word (word width = WORD_PIX*PIXEL_W)
//   - fetch_state_e: fetcher FSM encoding
//   - cnt_w(): counter width helper that never returns 0
package ref_fetch_pkg;

   localparam int PIXEL_W_DEF  = 8;
   localparam int ROW_PIX_DEF  = 15;
   localparam int NUM_ROWS_DEF = 15;
   localparam int ADDR_W_DEF   = 16;
   localparam int WORD_PIX     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_CAP,
      ST_DRAIN
   } fetch_state_e;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/row_skid_fifo.sv
// row_skid_fifo
//   Two-entry FIFO holding assembled reference rows between the fetch FSM
//   and the interpolator. Push and pop in the same cycle on a full FIFO is
//   legal and keeps occupancy at 2. head_data reads 0 while empty so the
//   row bus is quiet outside valid rows.
// Ports
//   clk, rst        clock, async active-low reset
//   push, push_data write one row (dropped if full and not popping)
//   pop             remove head (ignored while empty)
//   head_data       current head row
//   head_valid      FIFO not empty
//   count           occupancy 0..2
module row_skid_fifo #(
   parameter int DW = 120
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_valid,
   output logic [1:0]    count
);

   logic [DW-1:0] ent [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    cnt;
   logic          do_pop;
   logic          do_push;

   assign do_pop  = pop && (cnt != 2'd0);
   assign do_push = push && ((cnt != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) ent[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            ent[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_valid = (cnt != 2'd0);
   assign head_data  = head_valid ? ent[rd_ptr] : '0;
   assign count      = cnt;

endmodule

// File: rtl/ref_row_fetcher.sv
// ref_row_fetcher
//   Fetches a NUM_ROWS x ROW_PIX block of reference pixels, two memory words
//   per row (low word: pixels 0..7, high word: pixels 8..ROW_PIX-1), and
//   hands rows to the interpolator through a 2-entry FIFO. One row every 3
//   cycles when the consumer keeps up; the next row's reads are only issued
//   when a FIFO slot is certain to be free when its data lands.
//   Optional macro FETCHER_PAD_EN: rows at or below frame_rows reuse the
//   address of the last valid frame line (bottom-edge replication).
//   Assumes WORD_PIX < ROW_PIX <= 2*WORD_PIX.
// Ports
//   clk, rst            clock, async active-low reset
//   start               begin a block (ignored unless idle)
//   base_addr, stride   block origin and words per frame line (sampled on start)
//   frame_rows          valid lines below base_addr (padding build only)
//   mem_rd_en, mem_addr read request; mem_rdata returns one cycle later
//   row_out, row_valid, row_ready   row handshake, pixel i at [i*PIXEL_W +: PIXEL_W]
//   busy                block in progress
//   done                pulse after the last row is accepted
module ref_row_fetcher
   import ref_fetch_pkg::*;
#(
   parameter int PIXEL_W  = PIXEL_W_DEF,
   parameter int ROW_PIX  = ROW_PIX_DEF,
   parameter int NUM_ROWS = NUM_ROWS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          base_addr,
   input  logic [ADDR_W-1:0]          stride,
   input  logic [7:0]                 frame_rows,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [WORD_PIX*PIXEL_W-1:0] mem_rdata,
   output logic [ROW_PIX*PIXEL_W-1:0] row_out,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int MEM_W  = WORD_PIX * PIXEL_W;
   localparam int ROW_W  = ROW_PIX * PIXEL_W;
   localparam int HI_W   = (ROW_PIX - WORD_PIX) * PIXEL_W;
   localparam int RIDX_W = cnt_w(NUM_ROWS);
   localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(NUM_ROWS - 1);

   fetch_state_e      state, state_nxt;
   logic [RIDX_W-1:0] row_idx;
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] stride_q;
   logic [MEM_W-1:0]  lo_q;
   logic              cap_done;
   logic              done_q;

   logic              push;
   logic              pop;
   logic [ROW_W-1:0]  push_data;
   logic [1:0]        fifo_cnt;
   logic [1:0]        occ_after;
   logic              advance;
   logic              step_addr;

   // high-word pixels beyond ROW_PIX are dropped
   logic unused_hi;
   assign unused_hi = ^mem_rdata[MEM_W-1:HI_W];

`ifdef FETCHER_PAD_EN
   logic [7:0] frame_q;
   logic [8:0] frame_eff;
   logic [8:0] nxt_row;

   // frame_rows=0 behaves as a single valid line
   assign frame_eff = (frame_q == 8'd0) ? 9'd1 : {1'b0, frame_q};
   assign nxt_row   = 9'(row_idx) + 9'd1;
   // stop stepping once the next row would fall below the frame
   assign step_addr = (nxt_row < frame_eff);
`else
   logic unused_frame;
   assign unused_frame = ^frame_rows;
   assign step_addr    = 1'b1;
`endif

   // ---------------- FIFO ----------------
   // Exactly one push per row: on the first CAP cycle, while the high word
   // is on mem_rdata. A free slot is already guaranteed by the CAP decision
   // made before this row's reads were issued.
   assign push      = (state == ST_CAP) && !cap_done;
   assign push_data = {mem_rdata[HI_W-1:0], lo_q};
   assign pop       = row_valid && row_ready;
   assign occ_after = fifo_cnt + {1'b0, push} - {1'b0, pop};

   row_skid_fifo #(.DW(ROW_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (row_out),
      .head_valid(row_valid),
      .count     (fifo_cnt)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      advance   = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RD_LO;
         ST_RD_LO: state_nxt = ST_RD_HI;
         ST_RD_HI: state_nxt = ST_CAP;
         ST_CAP: begin
            if (row_idx == LAST_ROW) begin
               state_nxt = ST_DRAIN;
            end else if (occ_after < 2'd2) begin
               // occupancy cannot grow before the next CAP, so this slot holds
               state_nxt = ST_RD_LO;
               advance   = 1'b1;
            end
         end
         ST_DRAIN: if (occ_after == 2'd0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_idx  <= '0;
         row_addr <= '0;
         stride_q <= '0;
         lo_q     <= '0;
         cap_done <= 1'b0;
         done_q   <= 1'b0;
`ifdef FETCHER_PAD_EN
         frame_q  <= '0;
`endif
      end else begin
         if (state == ST_IDLE && start) begin
            row_idx  <= '0;
            row_addr <= base_addr;
            stride_q <= stride;
`ifdef FETCHER_PAD_EN
            frame_q  <= frame_rows;
`endif
         end else if (advance) begin
            row_idx <= row_idx + 1'b1;
            if (step_addr) row_addr <= row_addr + stride_q;
         end
         if (state == ST_RD_HI) lo_q <= mem_rdata;
         cap_done <= (state == ST_CAP) && (state_nxt == ST_CAP);
         // the last row is always the one leaving the FIFO when DRAIN empties
         done_q   <= (state == ST_DRAIN) && (occ_after == 2'd0);
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      case (state)
         ST_RD_LO: begin
            mem_rd_en = 1'b1;
            mem_addr  = row_addr;
         end
         ST_RD_HI: begin
            mem_rd_en = 1'b1;
            mem_addr  = row_addr + ADDR_W'(1);
         end
         default: ;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// tb_ref_row_fetcher
//   Randomized bench for ref_row_fetcher with a scoreboard. Stimulus pushes
//   the expected read addresses and rows of each block into queues; a
//   negedge monitor pops and compares on every read strobe and every row
//   transfer, and also checks hold stability, done/busy, and the FIFO slot
//   guard. Build with +define+FETCHER_PAD_EN to exercise padding.
module tb_ref_row_fetcher;

   localparam int PW = 8;
   localparam int RP = 15;
   localparam int NR = 15;
   localparam int AW = 16;
   localparam int MW = 8 * PW;
   localparam int RW = RP * PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] stride;
   logic [7:0]    frame_rows;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_rdata;
   logic [RW-1:0] row_out;
   logic          row_valid;
   logic          row_ready;
   logic          busy;
   logic          done;

   ref_row_fetcher #(.PIXEL_W(PW), .ROW_PIX(RP), .NUM_ROWS(NR), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .frame_rows(frame_rows), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .row_out(row_out), .row_valid(row_valid),
      .row_ready(row_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done = 0;
   int exp_done = 0;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled
   int t0 = 0;

   logic [RW-1:0] q_row[$];
   logic [AW-1:0] q_addr[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory content: distinct byte per (address, pixel)
   function automatic logic [MW-1:0] word_of(input logic [AW-1:0] a);
      logic [MW-1:0] w;
      for (int k = 0; k < 8; k++) w[k*PW +: PW] = 8'(int'(a) * 5 + k * 37 + int'(a >> 8) * 11);
      return w;
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                             input logic [7:0] f, input int r);
      int rr = r;
      int lim = (f == 8'd0) ? 1 : int'(f);
`ifndef FETCHER_PAD_EN
      lim = NR;
`endif
      if (rr > lim - 1) rr = lim - 1;
      return AW'(int'(b) + rr * int'(s));
   endfunction

   function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
      logic [MW-1:0] lo;
      logic [MW-1:0] hi;
      lo = word_of(a);
      hi = word_of(AW'(a + 16'd1));
      return {hi[RW-MW-1:0], lo};
   endfunction

   task automatic push_block(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [7:0] f);
      for (int r = 0; r < NR; r++) begin
         logic [AW-1:0] a;
         a = addr_of(b, s, f, r);
         q_addr.push_back(a);
         q_addr.push_back(AW'(a + 16'd1));
         q_row.push_back(row_of(a));
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [7:0] f);
      @(posedge clk); #1;
      base_addr = b; stride = s; frame_rows = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if (done) begin
            cycles = cyc - t0;
            break;
         end
      end
      if (cycles < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: no done within 3000 cycles");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"}, mem_rd_en, 1'b0);
      check({tag, "_addr"}, mem_addr, '0);
      check({tag, "_row_out"}, row_out, '0);
      check({tag, "_row_valid"}, row_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   // memory: data one cycle after the strobe, garbage otherwise
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= word_of(mem_addr);
      else           mem_rdata <= {$urandom, $urandom};
   end

   always @(posedge clk) cyc++;

   initial row_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       row_ready = 1'b1;
         1:       row_ready = 1'($urandom_range(0, 1));
         default: row_ready = 1'b0;
      endcase
   end

   // ---------------- monitor ----------------
   logic          hold = 1'b0;
   logic [RW-1:0] hold_row = '0;
   logic          done_exp = 1'b0;
   logic          rd_hi = 1'b0;
   int            lo_cnt = 0;
   int            xfers = 0;
   int            blk_x = 0;

   always @(negedge clk) begin
      if (!rst) begin
         hold = 1'b0; done_exp = 1'b0; rd_hi = 1'b0;
         lo_cnt = 0; xfers = 0; blk_x = 0;
      end else begin
         if (done || done_exp) begin
            check("done", done, done_exp);
            if (done_exp) check("busy_at_done", busy, 1'b0);
         end
         if (done) n_done++;
         done_exp = 1'b0;

         if (mem_rd_en) begin
            if (q_addr.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rd_addr: unexpected read at %h", mem_addr);
            end else begin
               check("rd_addr", mem_addr, q_addr.pop_front());
            end
            if (!rd_hi) begin
               lo_cnt++;
               // a new row may only start if its FIFO slot is certain
               check("slot_guard", (lo_cnt - xfers) <= 2, 1'b1);
            end
            rd_hi = ~rd_hi;
         end

         if (hold) begin
            check("hold_valid", row_valid, 1'b1);
            check("hold_data", row_out, hold_row);
         end

         if (row_valid && row_ready) begin
            if (q_row.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL row: unexpected row %h", row_out);
            end else begin
               check("row", row_out, q_row.pop_front());
            end
            xfers++;
            blk_x++;
            if (blk_x == NR) begin
               done_exp = 1'b1;
               blk_x = 0;
            end
         end
         hold     = row_valid && !row_ready;
         hold_row = row_out;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int cycles;
      int wait_n;
      logic [AW-1:0] target;

      rst = 1'b0; start = 1'b0; base_addr = '0; stride = '0; frame_rows = '0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // basic block: latency and throughput with ready held high
      push_block(16'h0100, 16'd4, 8'd15);
      do_start(16'h0100, 16'd4, 8'd15);
      repeat (3) @(negedge clk);
      check("latency_pre", row_valid, 1'b0);
      @(negedge clk);
      check("latency_first", row_valid, 1'b1);
      wait_done(cycles);
      check("start_to_done", cycles, 3 * (NR - 1) + 4);
      exp_done++;

      // consumer stalls for 10 cycles after the first row
      push_block(16'h0400, 16'd7, 8'd15);
      do_start(16'h0400, 16'd7, 8'd15);
      wait_n = 0;
      while (!row_valid && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      rdy_mode = 2;
      repeat (11) @(posedge clk);
      rdy_mode = 0;
      wait_done(cycles);
      exp_done++;

      // address wrap with a random consumer
      rdy_mode = 1;
      push_block(16'hFFFE, 16'd1, 8'd15);
      do_start(16'hFFFE, 16'd1, 8'd15);
      wait_done(cycles);
      exp_done++;
      rdy_mode = 0;

      // short frame (replicated rows in the padding build)
      push_block(16'h0300, 16'd16, 8'd5);
      do_start(16'h0300, 16'd16, 8'd5);
      wait_done(cycles);
      exp_done++;

      // reset while the high word of row 7 is being read
      push_block(16'h0200, 16'd3, 8'd15);
      do_start(16'h0200, 16'd3, 8'd15);
      target = AW'(addr_of(16'h0200, 16'd3, 8'd15, 7) + 16'd1);
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!(mem_rd_en && mem_addr == target) && wait_n < 200);
      check("reached_row7_hi", mem_addr, target);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      q_row.delete();
      q_addr.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      push_block(16'h0500, 16'd5, 8'd15);
      do_start(16'h0500, 16'd5, 8'd15);
      wait_done(cycles);
      exp_done++;

      // start pulsed while busy must be ignored
      push_block(16'h0600, 16'd2, 8'd15);
      do_start(16'h0600, 16'd2, 8'd15);
      repeat (8) @(posedge clk);
      #1 base_addr = 16'h7777; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(cycles);
      exp_done++;
      repeat (30) @(posedge clk);
      #2;
      check("idle_after_block_valid", row_valid, 1'b0);
      check("idle_after_block_busy", busy, 1'b0);
      check("rows_left", q_row.size(), 0);

      // random blocks
      rdy_mode = 1;
      for (int b = 0; b < 6; b++) begin
         logic [AW-1:0] rb;
         logic [AW-1:0] rs;
         logic [7:0]    rf;
         rb = AW'($urandom);
         rs = AW'($urandom_range(0, 16'hFFFF));
         rf = 8'($urandom_range(0, 20));
         push_block(rb, rs, rf);
         do_start(rb, rs, rf);
         wait_done(cycles);
         exp_done++;
      end
      rdy_mode = 0;

      repeat (10) @(posedge clk);
      #2;
      check("done_count", n_done, exp_done);
      check("rows_left_end", q_row.size(), 0);
      check("addrs_left_end", q_addr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
